// File: rtl/aes_stream_adapter_pkg.sv
// Shared AES adapter definitions: FSM state encoding and stream word width.
package aes_stream_adapter_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT,
    DRAIN
  } adapter_state_t;

endpackage

// File: rtl/aes_stream_adapter.sv
// Bridges a 32-bit valid/ready word stream to a 128-bit AES core:
// gathers four words, starts the core, waits with a timeout, drains the result.
module aes_stream_adapter
  import aes_stream_adapter_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_enc_dec,
  input  logic [1:0]        in_mode,
  output logic              core_start,
  output logic              core_enc_dec,
  output logic [1:0]        core_mode,
  output logic [127:0]      core_data_in,
  input  logic [127:0]      core_data_out,
  input  logic              core_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  adapter_state_t state, next_state;
  logic [1:0]    in_cnt, out_cnt;
  logic [CW-1:0] wait_cnt;
  logic [127:0]  result;
  logic          in_xfer, out_xfer, wait_expired;

  assign in_xfer      = in_valid && in_ready;
  assign out_xfer     = out_valid && out_ready;
  assign wait_expired = (wait_cnt == CNT_LAST);

  // Word k occupies bits [127-32k -: 32]; {~k, 5'h1f} is exactly 127-32k.
  assign out_data = result[{~out_cnt, 5'h1f} -: WORD_W];

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    in_ready    = 1'b0;
    core_start  = 1'b0;
    out_valid   = 1'b0;
    err_timeout = 1'b0;
    if (!reset) begin
      case (state)
        LOAD: begin
          in_ready = 1'b1;
          if (in_valid && in_cnt == 2'd3) next_state = START;
        end
        START: begin
          core_start = 1'b1;
          next_state = WAIT;
        end
        WAIT: begin
          // A result arriving on the final allowed cycle still wins.
          if (core_done) next_state = DRAIN;
          else if (wait_expired) begin
            err_timeout = 1'b1;
            next_state  = LOAD;
          end
        end
        DRAIN: begin
          out_valid = 1'b1;
          if (out_ready && out_cnt == 2'd3) next_state = LOAD;
        end
        default: next_state = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt       <= 2'd0;
      out_cnt      <= 2'd0;
      wait_cnt     <= '0;
      core_enc_dec <= 1'b0;
      core_mode    <= 2'b00;
    end else begin
      if (in_xfer) begin
        in_cnt <= in_cnt + 2'd1;
        if (in_cnt == 2'd0) begin
          core_enc_dec <= in_enc_dec;
          core_mode    <= in_mode;
        end
      end
      if (state == WAIT) begin
        if (core_done || wait_expired) wait_cnt <= '0;
        else                           wait_cnt <= wait_cnt + CNT_ONE;
      end
      if (out_xfer) out_cnt <= out_cnt + 2'd1;
    end
  end

  // Data registers carry no reset; the control path alone discards stale contents.
  always_ff @(posedge clk) begin
    if (!reset && in_xfer) core_data_in[{~in_cnt, 5'h1f} -: WORD_W] <= in_data;
    if (!reset && state == WAIT && core_done) result <= core_data_out;
  end

endmodule

// File: doc/aes_stream_adapter.md
AES_STREAM_ADAPTER -- requirements
Module: aes_stream_adapter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: maximum WAIT cycles before a block is abandoned.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: upstream word valid.
REQ-005 SHALL have port in_ready, output, 1: adapter accepts a word this cycle.
REQ-006 SHALL have port in_data, input, 32: plaintext/ciphertext word.
REQ-007 SHALL have port in_enc_dec, input, 1: 1 = decipher, 0 = encipher; sampled with word 0.
REQ-008 SHALL have port in_mode, input, 2: key size select (00 = 128, 01 = 192, 10 = 256); sampled with word 0.
REQ-009 SHALL have port core_start, output, 1: start pulse to the AES core.
REQ-010 SHALL have port core_enc_dec, output, 1: latched direction to the core.
REQ-011 SHALL have port core_mode, output, 2: latched mode to the core.
REQ-012 SHALL have port core_data_in, output, 128: assembled block to the core.
REQ-013 SHALL have port core_data_out, input, 128: core result.
REQ-014 SHALL have port core_done, input, 1: core result valid.
REQ-015 SHALL have port out_valid, output, 1: result word valid.
REQ-016 SHALL have port out_ready, input, 1: downstream accepts the word.
REQ-017 SHALL have port out_data, output, 32: result word.
REQ-018 SHALL have port err_timeout, output, 1: one-cycle pulse when a block is abandoned.

Function
REQ-019 SHALL implement a four-state FSM: LOAD -> START -> WAIT -> DRAIN -> LOAD.
REQ-020 SHALL drive in_ready = 1 only in LOAD; a transfer occurs when in_valid && in_ready.
REQ-021 SHALL write word k (k = 0..3, 2-bit counter) into core_data_in[127-32k -: 32]; word 0 fills [127:96].
REQ-022 SHALL latch in_enc_dec and in_mode into core_enc_dec/core_mode on the word-0 transfer and hold them until the next word 0.
REQ-023 SHALL move LOAD -> START on the word-3 transfer and wrap the word counter to 0.
REQ-024 SHALL assert core_start for exactly one cycle (the START state), then enter WAIT.
REQ-025 SHALL hold core_data_in stable from START until DRAIN is entered or the block is abandoned.
REQ-026 SHALL ignore core_done in LOAD, START and DRAIN.
REQ-027 In WAIT with core_done = 1, SHALL capture core_data_out into an output register, clear the timeout counter, and enter DRAIN.
REQ-028 SHALL count WAIT cycles; if TIMEOUT cycles elapse with no core_done, SHALL pulse err_timeout for one cycle, discard the block, and return to LOAD.
REQ-029 If core_done arrives in the same cycle the count reaches TIMEOUT, SHALL give core_done priority: no error, enter DRAIN.
REQ-030 In DRAIN, SHALL drive out_valid = 1 and present out_data = result[127-32k -: 32] for k = 0..3.
REQ-031 SHALL advance k only when out_valid && out_ready, holding out_data stable while out_ready = 0.
REQ-032 SHALL return to LOAD after the word-3 output handshake; the earliest next input transfer is the following cycle.
REQ-033 SHALL not accept input during START, WAIT or DRAIN (no overlap; one block in flight).

Reset
REQ-034 On reset, SHALL enter LOAD and clear both word counters and the timeout counter.
REQ-035 On reset, SHALL drive in_ready = 0 during the reset cycle, core_start = 0, out_valid = 0, err_timeout = 0, and core_enc_dec/core_mode = 0.
REQ-036 Reset mid-operation SHALL discard any partial input or result with no core_start or out_valid emitted afterwards; the data registers need not be cleared.

Structure
REQ-037 SHALL place the FSM state enum (LOAD, START, WAIT, DRAIN) and the word-width constant 32 in the shared AES package.
REQ-038 SHALL have no sub-module; the adapter connects directly to aes_core_gen ports.

Verification
REQ-039 Load words 00112233, 44556677, 8899aabb, ccddeeff with mode 00 and enc 0 -> one core_start pulse; core_data_in = 00112233445566778899aabbccddeeff.
REQ-040 Core model returns 69c4e0d86a7b0430d8cdb78070b4c55a on core_done -> out_data sequence 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
REQ-041 Hold out_ready = 0 for 5 cycles mid-drain -> out_data stable, no word lost or duplicated.
REQ-042 Core never asserts core_done -> err_timeout pulses at WAIT cycle 64, returns to LOAD, no out_valid.
REQ-043 Assert reset after 2 words -> the next 4 words form a fresh block, word 0 at [127:96].
REQ-044 Assert core_done at the exact timeout cycle -> DRAIN entered, err_timeout stays 0.
